// File: rtl/alu_flag_stage_pkg.sv
// Shared types and constants for the ALU flag output stage: data width,
// flag bit positions, the stored entry format and the skid-buffer state encoding.
package alu_pkg;

   localparam int DATA_W = 32;

   // Bit positions inside alu_entry_t.flags
   localparam int FLAG_ZERO  = 0;
   localparam int FLAG_NEG   = 1;
   localparam int FLAG_CARRY = 2;
   localparam int FLAG_OVF   = 3;

   // One stored result: 32-bit sum plus four status flags (36 bits)
   typedef struct packed {
      logic [31:0] sum;
      logic [3:0]  flags;
   } alu_entry_t;

   // Occupancy of the 2-entry skid buffer
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      TWO   = 2'b10
   } state_t;

endpackage : alu_pkg

// File: rtl/alu_flag_stage_if.sv
// Handshake and data bundle between the adder, the flag stage and its consumer.
// slave: the flag stage's view; master: the surrounding environment's view.
interface alu_flag_stage_if;
   import alu_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_sum;
   logic              in_carry;
   logic              in_ovf;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_sum;
   logic              out_zero;
   logic              out_neg;
   logic              out_carry;
   logic              out_ovf;

   modport slave (
      input  in_valid, in_sum, in_carry, in_ovf, out_ready,
      output in_ready, out_valid, out_sum, out_zero, out_neg, out_carry, out_ovf
   );

   modport master (
      output in_valid, in_sum, in_carry, in_ovf, out_ready,
      input  in_ready, out_valid, out_sum, out_zero, out_neg, out_carry, out_ovf
   );

endinterface : alu_flag_stage_if

// File: rtl/alu_flag_stage_skid_buf_2.sv
// skid_buf_2: generic 2-entry skid buffer. All handshake outputs are
// registered; in_ready never depends combinationally on out_ready.
module skid_buf_2 #(
   parameter int W = 36
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);
   import alu_pkg::*;

   state_t       state;
   logic [W-1:0] main_q;
   logic [W-1:0] skid_q;
   logic         in_xfer;
   logic         out_xfer;

   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = out_valid && out_ready;
   assign out_data = main_q;

   // Occupancy FSM: loads main/skid entries and registers the handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= EMPTY;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         // NOTE: both entries are reset, not only the valid bit, so out_* read 0 after reset.
         main_q    <= '0;
         skid_q    <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout; every register updates from pre-edge values.
         case (state)
            EMPTY: begin
               if (in_xfer) begin
                  main_q    <= in_data;
                  out_valid <= 1'b1;
                  state     <= ONE;
               end
            end
            ONE: begin
               if (in_xfer && out_xfer) begin
                  main_q <= in_data;
               end else if (in_xfer) begin
                  skid_q   <= in_data;
                  in_ready <= 1'b0;
                  state    <= TWO;
               end else if (out_xfer) begin
                  out_valid <= 1'b0;
                  state     <= EMPTY;
               end
            end
            TWO: begin
               if (out_xfer) begin
                  main_q   <= skid_q;
                  in_ready <= 1'b1;
                  state    <= ONE;
               end
            end
            default: begin
               state     <= EMPTY;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule : skid_buf_2

// File: rtl/zero_check.sv
// Combinational 32-bit zero detector.
module zero_check (
   input  logic [31:0] data,
   output logic        zero
);

   assign zero = (data == 32'd0);

endmodule : zero_check

// File: rtl/alu_flag_stage.sv
// alu_flag_stage: derives zero/neg/carry/ovf for each adder result and
// presents result plus flags through a registered 2-entry skid buffer.
// Optional feature macro: STICKY_FLAGS_EN adds sticky zero/carry/ovf bits
// on out_sticky[2:0] = {ovf, carry, zero}, cleared by flags_clr.
module alu_flag_stage #(
   parameter int DATA_W = alu_pkg::DATA_W
) (
   input  logic                clk,
   input  logic                rst_n,
   alu_flag_stage_if.slave     bus,
   input  logic                flags_clr
`ifdef STICKY_FLAGS_EN
   ,
   output logic [2:0]          out_sticky
`endif
);
   import alu_pkg::*;

   // The zero detector and entry format are fixed at 32 bits
   if (DATA_W != 32) begin : g_bad_width
      $error("alu_flag_stage: DATA_W must be 32");
   end

   logic       zero;
   alu_entry_t in_entry;
   alu_entry_t out_entry;

   zero_check u_zero_check (
      .data (bus.in_sum),
      .zero (zero)
   );

   // Assemble the entry to capture: sum plus flags derived from the input side
   always_comb begin
      // NOTE: default first so every bit is assigned on every pass and no latch is inferred.
      in_entry                    = '0;
      in_entry.sum                = bus.in_sum;
      in_entry.flags[FLAG_ZERO]   = zero;
      in_entry.flags[FLAG_NEG]    = bus.in_sum[31];
      in_entry.flags[FLAG_CARRY]  = bus.in_carry;
      in_entry.flags[FLAG_OVF]    = bus.in_ovf;
   end

   skid_buf_2 #(
      .W ($bits(alu_entry_t))
   ) u_skid_buf_2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (bus.in_valid),
      .in_ready  (bus.in_ready),
      .in_data   (in_entry),
      .out_valid (bus.out_valid),
      .out_ready (bus.out_ready),
      .out_data  (out_entry)
   );

   assign bus.out_sum   = out_entry.sum;
   assign bus.out_zero  = out_entry.flags[FLAG_ZERO];
   assign bus.out_neg   = out_entry.flags[FLAG_NEG];
   assign bus.out_carry = out_entry.flags[FLAG_CARRY];
   assign bus.out_ovf   = out_entry.flags[FLAG_OVF];

`ifdef STICKY_FLAGS_EN
   logic       out_xfer;
   logic [2:0] xfer_flags;
   logic [2:0] sticky;

   assign out_xfer   = bus.out_valid && bus.out_ready;
   assign xfer_flags = {out_entry.flags[FLAG_OVF], out_entry.flags[FLAG_CARRY],
                        out_entry.flags[FLAG_ZERO]};
   assign out_sticky = sticky;

   // Accumulate flags of every output transfer; a clear keeps the same-cycle transfer's flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky <= '0;
      end else if (flags_clr) begin
         sticky <= out_xfer ? xfer_flags : 3'b000;
      end else if (out_xfer) begin
         sticky <= sticky | xfer_flags;
      end
   end
`else
   logic unused_flags_clr;
   assign unused_flags_clr = flags_clr;
`endif

endmodule : alu_flag_stage

// File: tb/tb_alu_flag_stage.sv
// Self-checking bench for alu_flag_stage: table-driven streaming vectors,
// a scoreboard queue fed on input transfers and drained on output transfers,
// and hand-written reset / backpressure / sticky sequences.
module tb_alu_flag_stage;

   typedef struct {
      logic [31:0] sum;
      logic        zero;
      logic        neg;
      logic        carry;
      logic        ovf;
   } exp_t;

   typedef struct {
      logic [31:0] sum;
      logic        carry;
      logic        ovf;
      logic        exp_zero;
      logic        exp_neg;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flags_clr = 1'b0;
`ifdef STICKY_FLAGS_EN
   logic [2:0] out_sticky;
`endif

   int   pass_cnt = 0;
   int   total_cnt = 0;
   exp_t sb[$];
   exp_t cur_exp;

   alu_flag_stage_if bus ();

   alu_flag_stage dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .flags_clr (flags_clr)
`ifdef STICKY_FLAGS_EN
      ,
      .out_sticky(out_sticky)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one input beat; expected flags are supplied by the caller
   task automatic drive(input logic [31:0] s, input logic c, input logic o,
                        input logic ez, input logic en);
      bus.in_valid = 1'b1;
      bus.in_sum   = s;
      bus.in_carry = c;
      bus.in_ovf   = o;
      cur_exp      = '{sum: s, zero: ez, neg: en, carry: c, ovf: o};
   endtask

   // Scoreboard: at the falling edge, compare the presented entry and record new inputs
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.out_valid) begin
            if (sb.size() == 0) begin
               check("sb_unexpected_out", 64'(sb.size()), 64'd1);
            end else begin
               check("sb_sum",   64'(bus.out_sum),   64'(sb[0].sum));
               check("sb_zero",  64'(bus.out_zero),  64'(sb[0].zero));
               check("sb_neg",   64'(bus.out_neg),   64'(sb[0].neg));
               check("sb_carry", 64'(bus.out_carry), 64'(sb[0].carry));
               check("sb_ovf",   64'(bus.out_ovf),   64'(sb[0].ovf));
               if (bus.out_ready) void'(sb.pop_front());
            end
         end
         if (bus.in_valid && bus.in_ready) sb.push_back(cur_exp);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t vecs[8];
      vecs[0] = '{32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[1] = '{32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[3] = '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[4] = '{32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{32'h0001_0000, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{32'h8000_0001, 1'b1, 1'b1, 1'b0, 1'b1};
      vecs[7] = '{32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b0};

      // Reset held with in_valid asserted: nothing may be captured
      drive(32'h1234_5678, 1'b1, 1'b1, 1'b0, 1'b0);
      bus.out_ready = 1'b1;
      repeat (3) tick();
      check("rst_in_ready",  64'(bus.in_ready),  64'd1);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out_sum",   64'(bus.out_sum),   64'd0);
      check("rst_out_flags", 64'({bus.out_zero, bus.out_neg, bus.out_carry, bus.out_ovf}), 64'd0);
      bus.in_valid = 1'b0;
      rst_n = 1'b1;
      tick();
      check("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("post_rst_in_ready",  64'(bus.in_ready),  64'd1);

      // Single transfer of a zero sum with carry
      drive(32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      bus.in_valid = 1'b0;
      check("single_valid", 64'(bus.out_valid), 64'd1);
      check("single_zero",  64'(bus.out_zero),  64'd1);
      check("single_neg",   64'(bus.out_neg),   64'd0);
      check("single_carry", 64'(bus.out_carry), 64'd1);
      tick();
      check("single_drain", 64'(bus.out_valid), 64'd0);

      // Streaming table: one result per cycle, 1-cycle latency, in order
      for (int i = 0; i < 8; i++) begin
         drive(vecs[i].sum, vecs[i].carry, vecs[i].ovf, vecs[i].exp_zero, vecs[i].exp_neg);
         tick();
         check($sformatf("stream_valid_%0d", i), 64'(bus.out_valid), 64'd1);
         check($sformatf("stream_sum_%0d", i),   64'(bus.out_sum),   64'(vecs[i].sum));
         check($sformatf("stream_ready_%0d", i), 64'(bus.in_ready),  64'd1);
      end
      bus.in_valid = 1'b0;
      tick();
      check("stream_drain", 64'(bus.out_valid), 64'd0);
      check("stream_sb_empty", 64'(sb.size()), 64'd0);

      // Backpressure: A then B fill both entries, extra beat C is ignored
      bus.out_ready = 1'b0;
      drive(32'h0000_000A, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      check("bp_ready_after_a", 64'(bus.in_ready), 64'd1);
      drive(32'h0000_000B, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      check("bp_ready_full", 64'(bus.in_ready), 64'd0);
      drive(32'h0000_000C, 1'b0, 1'b1, 1'b0, 1'b0);
      repeat (3) tick();
      check("bp_hold_sum",   64'(bus.out_sum),   64'h0A);
      check("bp_hold_valid", 64'(bus.out_valid), 64'd1);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      check("bp_second_sum", 64'(bus.out_sum),  64'h0B);
      check("bp_ready_back", 64'(bus.in_ready), 64'd1);
      tick();
      check("bp_drain", 64'(bus.out_valid), 64'd0);
      check("bp_sb_empty", 64'(sb.size()), 64'd0);

      // Asynchronous reset while both entries are occupied
      bus.out_ready = 1'b0;
      drive(32'h0000_0111, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      drive(32'h0000_0222, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      bus.in_valid = 1'b0;
      check("mid_full", 64'(bus.in_ready), 64'd0);
      #2;
      rst_n = 1'b0;
      #1;
      sb.delete();
      check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("mid_rst_in_ready",  64'(bus.in_ready),  64'd1);
      check("mid_rst_out_sum",   64'(bus.out_sum),   64'd0);
      tick();
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("mid_no_stale_%0d", i), 64'(bus.out_valid), 64'd0);
      end

`ifdef STICKY_FLAGS_EN
      // Sticky ovf survives a later transfer without ovf
      drive(32'h0000_0005, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      drive(32'h0000_0006, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      bus.in_valid = 1'b0;
      repeat (2) tick();
      check("sticky_ovf", 64'(out_sticky), 64'b100);
      // Clear coinciding with a zero-result transfer keeps only that transfer's flags
      drive(32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      bus.in_valid = 1'b0;
      flags_clr = 1'b1;
      tick();
      flags_clr = 1'b0;
      check("sticky_clr_xfer", 64'(out_sticky), 64'b001);
      tick();
`endif

      check("final_sb_empty", 64'(sb.size()), 64'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule : tb_alu_flag_stage

// File: doc/alu_flag_stage.md
Name: alu_flag_stage

Overview:
- Registered output stage directly downstream of the 32-bit adder and consumer of the combinational zero detector.
- Accepts one adder result per valid/ready handshake, derives the zero, negative, carry and overflow status flags, and holds result plus flags in a 2-entry skid buffer.
- Gives the next pipeline stage a fully registered interface and breaks the adder-to-consumer timing path.

Parameters:
- DATA_W, 32, result width; fixed at 32 because the zero detector is 32-bit only. Any other value is an elaboration error.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream result valid
- in_ready  output  1  stage can accept; registered
- in_sum  input  DATA_W  adder sum
- in_carry  input  1  adder carry-out
- in_ovf  input  1  adder signed overflow
- out_valid  output  1  output entry valid; registered
- out_ready  input  1  downstream accepts
- out_sum  output  DATA_W  registered sum
- out_zero  output  1  sum == 0
- out_neg  output  1  sum[DATA_W-1]
- out_carry  output  1  registered carry
- out_ovf  output  1  registered overflow
- flags_clr  input  1  clears sticky flags (only meaningful with STICKY_FLAGS_EN)

Behaviour:
- Reset (async assert, sync deassert by the integrator):
  - in_ready=1, out_valid=0.
  - out_sum=0, out_zero=0, out_neg=0, out_carry=0, out_ovf=0.
  - State EMPTY; both entries cleared.
- Transfer rules:
  - Input transfer occurs when in_valid&&in_ready.
  - Output transfer occurs when out_valid&&out_ready.
- Flag derivation, combinational on the input side before capture:
  - zero from the zero_check instance on in_sum.
  - neg = in_sum[31].
  - carry and ovf pass through.
  - Each entry stores {sum, zero, neg, carry, ovf}, 36 bits.
- Latency: 1 cycle from input transfer to out_valid when the stage is empty.
- Throughput: 1 per cycle while out_ready=1.
- Storage:
  - Main entry drives the outputs.
  - Skid entry holds a second result when the main entry is stalled.
- FSM:
  - EMPTY: input transfer -> load main, go to ONE.
  - ONE:
    - Input and output transfer together -> reload main, stay ONE.
    - Input only -> load skid, go to TWO.
    - Output only -> go to EMPTY.
    - Neither -> hold.
  - TWO: in_ready=0. Output transfer -> main<=skid, go to ONE. Otherwise hold.
- in_ready is registered and equals (next_state != TWO). No combinational path from out_ready to in_ready.
- Output hold rule: while out_valid=1 and out_ready=0, all out_* fields hold stable.
- When out_valid=0, out_* fields hold their last values. The bench checks them only when valid.
- in_valid while in_ready=0: ignored, no capture. Upstream must hold its data.
- Async reset mid-transfer: all entries are discarded and outputs return to their reset values immediately; no partial entry survives.
- Simultaneous transfers in TWO are impossible, since in_ready=0 there.

Optional Feature:
- Macro: STICKY_FLAGS_EN.
- Defined:
  - Adds sticky registers sticky_zero, sticky_carry, sticky_ovf, exported as out_sticky[2:0].
  - Each sticky bit is the OR of the corresponding flag over every output transfer since reset or the last flags_clr.
  - flags_clr=1 clears all sticky bits that cycle.
  - If flags_clr and an output transfer happen in the same cycle, the result is the new transfer's flags only, not zero.
  - Reset value 0.
- Undefined: no sticky logic, out_sticky port absent, flags_clr unconnected and ignored.

Decomposition:
- Shared package (alu_pkg):
  - DATA_W=32.
  - Flag bit indices FLAG_ZERO=0, FLAG_NEG=1, FLAG_CARRY=2, FLAG_OVF=3.
  - Packed entry type alu_entry_t {sum[31:0], flags[3:0]}.
  - FSM state encoding EMPTY=2'b00, ONE=2'b01, TWO=2'b10.
- Sub-modules:
  - zero_check, the existing team module, instantiated once on in_sum.
  - One natural new sub-module, skid_buf_2, a generic 2-entry skid buffer parameterised on entry width. It carries the FSM and handshake.
  - The top level adds flag derivation and the optional sticky logic.

Test Plan:
- Reset with in_valid=1 held -> after rst_n rises, in_ready=1, out_valid=0, all outputs 0; first capture only after rst_n=1.
- Single transfer in_sum=32'h0000_0000, carry=1, ovf=0, out_ready=1 -> next cycle out_valid=1, out_zero=1, out_neg=0, out_carry=1; following cycle out_valid=0.
- Streaming 8 results 32'h8000_0000, 32'h1, ... with out_ready=1 every cycle -> one output per cycle, 1-cycle latency, in order; 32'h8000_0000 gives out_neg=1, out_zero=0.
- Backpressure: out_ready=0, push 32'hA, then 32'hB -> in_ready drops to 0 after the second push; outputs hold 32'hA. Raise out_ready -> 32'hA then 32'hB emitted in order, in_ready returns to 1, no loss or duplication.
- Mid-operation reset in state TWO -> out_valid=0 and in_ready=1 asynchronously; no stale entry emitted after release.
- STICKY_FLAGS_EN: transfers with ovf=1, then 0 -> out_sticky[ovf] stays 1. flags_clr in the same cycle as a transfer with zero=1 -> only sticky_zero=1 afterwards.
